// File: rtl/frame_buffer_writer.sv
// Write side of the frame buffer: turns a raster-ordered valid/ready pixel stream
// into linear block-RAM write strobes and flags when a complete frame is stored.
module frame_buffer_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                  clk_i_fbw,
  input  logic                  rst_ni_fbw,
  input  logic                  start_i_fbw,
  input  logic [DATA_WIDTH-1:0] pixel_i_fbw,
  input  logic                  valid_i_fbw,
  output logic                  ready_o_fbw,
  output logic                  ram_en_o_fbw,
  output logic                  ram_we_o_fbw,
  output logic [ADDR_WIDTH-1:0] ram_addr_o_fbw,
  output logic [DATA_WIDTH-1:0] ram_data_o_fbw,
  output logic [XW-1:0]         x_o_fbw,
  output logic [YW-1:0]         y_o_fbw,
  output logic                  busy_o_fbw,
  output logic                  write_to_ram_done_o_fbw,
  output logic                  overrun_o_fbw
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [XW-1:0]         X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0]         X_ONE   = XW'(1'b1);
  localparam logic [YW-1:0]         Y_ONE   = YW'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1'b1);

  state_e                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ram_en_q, ram_en_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    ovr_q, ovr_d;

  // Next-state logic: the linear count advances alongside x/y so no multiplier is needed.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    ram_en_d = 1'b0;
    ram_we_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = done_q;
    ovr_d    = ovr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i_fbw) begin
          state_d = ST_WRITE;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          ovr_d   = valid_i_fbw;
        end else begin
          ovr_d   = ovr_q | valid_i_fbw;
        end
      end
      ST_WRITE: begin
        if (valid_i_fbw) begin
          ram_en_d = 1'b1;
          ram_we_d = 1'b1;
          addr_d   = cnt_q;
          data_d   = pixel_i_fbw;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              y_d     = '0;
              cnt_d   = '0;
            end else begin
              y_d   = y_q + Y_ONE;
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            x_d   = x_q + X_ONE;
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i_fbw or negedge rst_ni_fbw) begin
    if (!rst_ni_fbw) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign ready_o_fbw             = (state_q == ST_WRITE);
  assign busy_o_fbw              = (state_q == ST_WRITE);
  assign ram_en_o_fbw            = ram_en_q;
  assign ram_we_o_fbw            = ram_we_q;
  assign ram_addr_o_fbw          = addr_q;
  assign ram_data_o_fbw          = data_q;
  assign x_o_fbw                 = x_q;
  assign y_o_fbw                 = y_q;
  assign write_to_ram_done_o_fbw = done_q;
  assign overrun_o_fbw           = ovr_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench: a 4x2 instance and a default 320x240 instance, each driven by
// random/directed stimulus and checked against a frame-index reference model.
module tb_frame_buffer_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       st    [2];
  logic       vl    [2];
  logic [7:0] px    [2];

  logic       rdy_s, en_s, we_s, busy_s, done_s, ovr_s;
  logic [2:0] addr_s;
  logic [7:0] data_s;
  logic [1:0] x_s;
  logic [0:0] y_s;

  logic        rdy_l, en_l, we_l, busy_l, done_l, ovr_l;
  logic [16:0] addr_l;
  logic [7:0]  data_l;
  logic [8:0]  x_l;
  logic [7:0]  y_l;

  frame_buffer_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_s (
    .clk_i_fbw(clk), .rst_ni_fbw(rst_n[0]), .start_i_fbw(st[0]), .pixel_i_fbw(px[0]),
    .valid_i_fbw(vl[0]), .ready_o_fbw(rdy_s), .ram_en_o_fbw(en_s), .ram_we_o_fbw(we_s),
    .ram_addr_o_fbw(addr_s), .ram_data_o_fbw(data_s), .x_o_fbw(x_s), .y_o_fbw(y_s),
    .busy_o_fbw(busy_s), .write_to_ram_done_o_fbw(done_s), .overrun_o_fbw(ovr_s));

  frame_buffer_writer dut_l (
    .clk_i_fbw(clk), .rst_ni_fbw(rst_n[1]), .start_i_fbw(st[1]), .pixel_i_fbw(px[1]),
    .valid_i_fbw(vl[1]), .ready_o_fbw(rdy_l), .ram_en_o_fbw(en_l), .ram_we_o_fbw(we_l),
    .ram_addr_o_fbw(addr_l), .ram_data_o_fbw(data_l), .x_o_fbw(x_l), .y_o_fbw(y_l),
    .busy_o_fbw(busy_l), .write_to_ram_done_o_fbw(done_l), .overrun_o_fbw(ovr_l));

  typedef struct {int rdy; int en; int we; int addr; int data; int x; int y; int busy; int done; int ovr;} obs_t;
  typedef struct {int addr; int data; int done; int tag;} exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // reference model: mode 0 idle, 1 writing, 2 frame complete; idx = pixels stored this frame
  int W[2] = '{4, 320};
  int H[2] = '{2, 240};
  int mode[2], idx[2], ovr_m[2], dn_m[2];

  function automatic obs_t sample(int k);
    obs_t o;
    if (k == 0) begin
      o.rdy = rdy_s; o.en = en_s; o.we = we_s; o.addr = addr_s; o.data = data_s;
      o.x = x_s; o.y = y_s; o.busy = busy_s; o.done = done_s; o.ovr = ovr_s;
    end else begin
      o.rdy = rdy_l; o.en = en_l; o.we = we_l; o.addr = addr_l; o.data = data_l;
      o.x = x_l; o.y = y_l; o.busy = busy_l; o.done = done_l; o.ovr = ovr_l;
    end
    return o;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: every RAM strobe must match the oldest expected write, on the expected cycle
  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    int   n;
    ncyc++;
    for (int k = 0; k < 2; k++) begin
      o = sample(k);
      if (o.en != 0 || o.we != 0) begin
        n = (k == 0) ? q0.size() : q1.size();
        if (n == 0) begin
          chk($sformatf("d%0d unexpected_write addr", k), o.addr, -1);
        end else begin
          if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("d%0d ram_en", k), o.en, 1);
          chk($sformatf("d%0d ram_we", k), o.we, 1);
          chk($sformatf("d%0d ram_addr", k), o.addr, e.addr);
          chk($sformatf("d%0d ram_data", k), o.data, e.data);
          chk($sformatf("d%0d done_with_write", k), o.done, e.done);
          chk($sformatf("d%0d write_cycle", k), ncyc, e.tag);
        end
      end
    end
  end

  // one clock of stimulus; entered and left at a falling edge
  task automatic step(int k, bit s, bit v, int p);
    obs_t o;
    exp_t e;
    int   D;
    D = W[k] * H[k];
    o = sample(k);
    chk($sformatf("d%0d ready", k), o.rdy, (mode[k] == 1) ? 1 : 0);
    chk($sformatf("d%0d busy", k), o.busy, (mode[k] == 1) ? 1 : 0);
    chk($sformatf("d%0d done", k), o.done, dn_m[k]);
    chk($sformatf("d%0d overrun", k), o.ovr, ovr_m[k]);
    chk($sformatf("d%0d x", k), o.x, idx[k] % W[k]);
    chk($sformatf("d%0d y", k), o.y, idx[k] / W[k]);
    st[k] = s;
    vl[k] = v;
    px[k] = p[7:0];
    @(posedge clk);
    if (mode[k] != 1) begin
      if (s) begin
        mode[k] = 1; idx[k] = 0; dn_m[k] = 0; ovr_m[k] = v ? 1 : 0;
      end else if (v) begin
        ovr_m[k] = 1;
      end
    end else if (v) begin
      e.addr = idx[k];
      e.data = p & 255;
      e.done = (idx[k] == D - 1) ? 1 : 0;
      e.tag  = ncyc + 1;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      idx[k]++;
      if (idx[k] == D) begin
        mode[k] = 2; dn_m[k] = 1; idx[k] = 0;
      end
    end
    @(negedge clk);
    st[k] = 1'b0;
    vl[k] = 1'b0;
  endtask

  // asynchronous reset pulse between edges, with valid high while it is applied
  task automatic do_reset(int k);
    obs_t o;
    #2;
    vl[k] = 1'b1; px[k] = 8'hAA; rst_n[k] = 1'b0;
    #1;
    o = sample(k);
    chk($sformatf("d%0d rst ready", k), o.rdy, 0);
    chk($sformatf("d%0d rst ram_en", k), o.en, 0);
    chk($sformatf("d%0d rst ram_we", k), o.we, 0);
    chk($sformatf("d%0d rst addr", k), o.addr, 0);
    chk($sformatf("d%0d rst data", k), o.data, 0);
    chk($sformatf("d%0d rst x", k), o.x, 0);
    chk($sformatf("d%0d rst y", k), o.y, 0);
    chk($sformatf("d%0d rst busy", k), o.busy, 0);
    chk($sformatf("d%0d rst done", k), o.done, 0);
    chk($sformatf("d%0d rst overrun", k), o.ovr, 0);
    mode[k] = 0; idx[k] = 0; ovr_m[k] = 0; dn_m[k] = 0;
    #1;
    vl[k] = 1'b0; rst_n[k] = 1'b1;
    @(negedge clk);
  endtask

  int pat[5] = '{1, 0, 1, 1, 0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; st[k] = 1'b0; vl[k] = 1'b0; px[k] = 8'h00;
      mode[k] = 0; idx[k] = 0; ovr_m[k] = 0; dn_m[k] = 0;
    end
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // small frame: idle after reset, overrun in idle, start priority, continuous stream
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0, 0);
    step(0, 1'b0, 1'b1, 8'h55);
    step(0, 1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, 8'h10 + i);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 8'h33);

    // restart from done, then gapped valid
    step(0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 60 && mode[0] == 1; i++)
      step(0, 1'b0, (i < 5) ? pat[i] != 0 : $urandom_range(0, 1) != 0, $urandom_range(0, 255));

    // random mix of starts and valids in every state
    for (int i = 0; i < 200; i++)
      step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 255));

    // small mid-frame reset
    step(0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, $urandom_range(0, 255));
    do_reset(0);
    step(0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, $urandom_range(0, 255));

    // default geometry: abandon after 1000 beats, then a full frame and a restart
    step(1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 1000; i++) step(1, 1'b0, 1'b1, $urandom_range(0, 255));
    do_reset(1);
    step(1, 1'b0, 1'b0, 0);
    step(1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 80000 && mode[1] == 1; i++) step(1, 1'b0, 1'b1, $urandom_range(0, 255));
    step(1, 1'b0, 1'b0, 0);
    step(1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1, 1'b0, 1'b1, $urandom_range(0, 255));
    for (int i = 0; i < 3; i++) step(1, 1'b0, 1'b0, 0);

    chk("d0 pending_writes", q0.size(), 0);
    chk("d1 pending_writes", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
